// File: rtl/edp_diag_pkg.sv
// Shared types for the EDP diagnostic read path: FSM states, the EBUS word, select-bit positions.
// Optional feature macro: EDP_DIAG_PAR_CHK_EN enables the per-slice FM parity helper's use.
package edp_diag_pkg;

  localparam int EBUS_W   = 36;
  localparam int SLICE_W  = 6;
  localparam int N_SLICES = EBUS_W / SLICE_W;
  localparam int CTR_W    = 8;

  // Positions of the 04/05/06 function low bits within req_func_h.
  localparam int SEL_04 = 2;
  localparam int SEL_05 = 1;
  localparam int SEL_06 = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_SAMP1,
    ST_SAMP2,
    ST_DONE,
    ST_RELEASE
  } diag_state_e;

  // PDP-10 bit numbering: bit 0 is ebus_d00 and is the most significant bit.
  typedef logic [0:EBUS_W-1] ebus_word_t;

  function automatic logic [N_SLICES-1:0] slice_par_err(input ebus_word_t w,
                                                        input logic [N_SLICES-1:0] fm_par);
    logic [N_SLICES-1:0] e;
    e = '0;
    for (int i = 0; i < N_SLICES; i++) begin
      e[i] = (^w[SLICE_W*i +: SLICE_W]) != fm_par[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/edp_diag_settle_ctr.sv
// Loadable down-counter with zero flag; the reader shares one instance between the
// SETTLE wait and the post-done HOLD wait, which never overlap.
module edp_diag_settle_ctr
  import edp_diag_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CTR_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CTR_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/edp_ebus_diag_reader.sv
// EBUS-side diag reader: selects a diag function on the EDP slices, double-samples the bus
// until stable (bounded retries) and returns the word. EDP_DIAG_PAR_CHK_EN adds FM parity check.
module edp_ebus_diag_reader
  import edp_diag_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int HOLD_CYC   = 2,
  parameter int MAX_RETRY  = 3
) (
  input  logic                clk_h,
  input  logic                crobar_h,
  input  logic                req_h,
  input  logic [2:0]          req_func_h,
  output logic                ack_h,
  output logic                busy_h,
  output logic                done_h,
  output ebus_word_t          rd_data_h,
  output logic                err_h,
  output logic                diag_read_func_12x_h,
  output logic                diag_04_a_h,
  output logic                diag_05_a_h,
  output logic                diag_06_a_h,
`ifdef EDP_DIAG_PAR_CHK_EN
  input  logic [N_SLICES-1:0] fm_parity_h,
  output logic [N_SLICES-1:0] par_err_h,
`endif
  input  ebus_word_t          ebus_d_e_h
);

  localparam logic [CTR_W-1:0] SETTLE_LD = CTR_W'(SETTLE_CYC - 1);
  localparam logic [CTR_W-1:0] RETRY_LD  = (SETTLE_CYC > 1) ? CTR_W'(SETTLE_CYC - 2) : '0;
  localparam logic [CTR_W-1:0] HOLD_LD   = CTR_W'(HOLD_CYC - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);
  // The SAMP2 clock of a failed pair counts as the first settle clock of the next pair,
  // so consecutive pairs start SETTLE_CYC+1 clocks apart.
  localparam diag_state_e      RETRY_ST  = (SETTLE_CYC > 1) ? ST_SETTLE : ST_SAMP1;

  diag_state_e      state_q;
  logic             ack_q, busy_q, done_q, err_q, func_q;
  logic [2:0]       sel_q;
  logic [2:0]       retry_q;
  ebus_word_t       rd_data_q;
  ebus_word_t       s1_q;
  logic             bus_eq;
  logic             ctr_load, ctr_dec, ctr_zero;
  logic [CTR_W-1:0] ctr_val;

  assign bus_eq = (ebus_d_e_h == s1_q);

  edp_diag_settle_ctr u_ctr (
    .clk_i      (clk_h),
    .rst_i      (crobar_h),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  always_comb begin
    ctr_load = 1'b0;
    ctr_val  = '0;
    ctr_dec  = 1'b0;
    case (state_q)
      ST_SETUP: begin
        ctr_load = 1'b1;
        ctr_val  = SETTLE_LD;
      end
      ST_SAMP2: begin
        if (!bus_eq) begin
          ctr_load = 1'b1;
          ctr_val  = RETRY_LD;
        end
      end
      ST_DONE: begin
        ctr_load = 1'b1;
        ctr_val  = HOLD_LD;
      end
      ST_SETTLE, ST_RELEASE: ctr_dec = 1'b1;
      default: ;
    endcase
  end

  // First sample of each pair; pure datapath, no reset needed.
  always_ff @(posedge clk_h) begin
    if (state_q == ST_SAMP1) begin
      s1_q <= ebus_d_e_h;
    end
  end

  always_ff @(posedge clk_h or posedge crobar_h) begin
    if (crobar_h) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      func_q    <= 1'b0;
      sel_q     <= '0;
      retry_q   <= '0;
      rd_data_q <= '0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_h) begin
            ack_q   <= 1'b1;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            sel_q   <= req_func_h;
            retry_q <= '0;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          func_q  <= 1'b1;
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (ctr_zero) state_q <= ST_SAMP1;
        end
        ST_SAMP1: state_q <= ST_SAMP2;
        ST_SAMP2: begin
          if (bus_eq || (retry_q == RETRY_MAX)) begin
            rd_data_q <= ebus_d_e_h;
            err_q     <= !bus_eq;
            done_q    <= 1'b1;
            func_q    <= 1'b0;
            state_q   <= ST_DONE;
          end else begin
            retry_q <= retry_q + 3'd1;
            state_q <= RETRY_ST;
          end
        end
        ST_DONE: begin
          sel_q   <= '0;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (ctr_zero) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack_h                = ack_q;
  assign busy_h               = busy_q;
  assign done_h               = done_q;
  assign err_h                = err_q;
  assign rd_data_h            = rd_data_q;
  assign diag_read_func_12x_h = func_q;
  assign diag_04_a_h          = sel_q[SEL_04];
  assign diag_05_a_h          = sel_q[SEL_05];
  assign diag_06_a_h          = sel_q[SEL_06];

`ifdef EDP_DIAG_PAR_CHK_EN
  logic [N_SLICES-1:0] par_err_q;

  // Parity is judged only on a stable pair; an unstable read reports no parity errors.
  always_ff @(posedge clk_h or posedge crobar_h) begin
    if (crobar_h) begin
      par_err_q <= '0;
    end else if (state_q == ST_SAMP2) begin
      par_err_q <= bus_eq ? slice_par_err(ebus_d_e_h, fm_parity_h) : '0;
    end
  end

  assign par_err_h = par_err_q;
`endif

endmodule

// File: tb/tb_edp_ebus_diag_reader.sv
// Scoreboard bench for edp_ebus_diag_reader: a driver issues reads with scripted EBUS behaviour,
// a reference model predicts each result, and a monitor checks it when done_h appears.
module tb_edp_ebus_diag_reader;
  import edp_diag_pkg::*;

  localparam int S  = 4;
  localparam int H  = 2;
  localparam int R  = 3;
  localparam int NK = 64;

  logic       clk_h = 1'b0;
  logic       crobar_h, req_h;
  logic [2:0] req_func_h;
  logic       ack_h, busy_h, done_h, err_h, f12, d04, d05, d06;
  ebus_word_t rd_data_h, ebus;
  logic [5:0] fm_cur;
`ifdef EDP_DIAG_PAR_CHK_EN
  logic [5:0] fm_parity_h, par_err_h;
  assign fm_parity_h = fm_cur;
`endif

  typedef struct {
    ebus_word_t data;
    logic       err;
    int         done_cyc;
    logic [5:0] par;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       me;
  ebus_word_t busv[NK];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         abort = 0;

  edp_ebus_diag_reader #(.SETTLE_CYC(S), .HOLD_CYC(H), .MAX_RETRY(R)) dut (
    .clk_h                (clk_h),
    .crobar_h             (crobar_h),
    .req_h                (req_h),
    .req_func_h           (req_func_h),
    .ack_h                (ack_h),
    .busy_h               (busy_h),
    .done_h               (done_h),
    .rd_data_h            (rd_data_h),
    .err_h                (err_h),
    .diag_read_func_12x_h (f12),
    .diag_04_a_h          (d04),
    .diag_05_a_h          (d05),
    .diag_06_a_h          (d06),
`ifdef EDP_DIAG_PAR_CHK_EN
    .fm_parity_h          (fm_parity_h),
    .par_err_h            (par_err_h),
`endif
    .ebus_d_e_h           (ebus)
  );

  always #5 clk_h = ~clk_h;
  always @(posedge clk_h) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ebus_word_t rnd_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[35:0];
  endfunction

  // Bus script indexed by clocks since ack (0 = ack clock). Sample pair p is taken on
  // clocks 1+S+p*(S+1) and the one after; the word shows up on done_h the clock after that.
  task automatic build(input int pat, input ebus_word_t w, input int g);
    ebus_word_t w2, m;
    int c;
    m = '0;
    m[$urandom_range(0, 35)] = 1'b1;
    w2 = w ^ m;
    c = $urandom_range(0, 2 + S + R * (S + 1));
    for (int k = 0; k < NK; k++) begin
      case (pat)
        1:       busv[k] = (k >= 2 + S + g * (S + 1)) ? w2 : w;
        2:       busv[k] = k[0] ? ~w : w;
        3:       busv[k] = rnd_word();
        4:       busv[k] = (k >= c) ? w : rnd_word();
        default: busv[k] = w;
      endcase
    end
  endtask

  function automatic exp_t model(input int acyc, input logic [5:0] fm);
    exp_t e;
    int a, b;
    e.data = '0; e.err = 1'b0; e.done_cyc = 0; e.par = '0;
    for (int p = 0; p <= R; p++) begin
      a = 1 + S + p * (S + 1);
      b = a + 1;
      if (busv[a] == busv[b] || p == R) begin
        e.data     = busv[b];
        e.err      = (busv[a] != busv[b]);
        e.done_cyc = acyc + b + 1;
        for (int i = 0; i < 6; i++) e.par[i] = e.err ? 1'b0 : ((^busv[b][6*i +: 6]) != fm[i]);
        break;
      end
    end
    return e;
  endfunction

  task automatic request(input logic [2:0] f, output int acyc);
    req_h = 1'b1;
    req_func_h = f;
    acyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_h); #1;
      if (ack_h) begin
        acyc = cyc;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL ack_timeout: no ack_h within 20 clks, required one");
    abort = 1;
  endtask

  // Entered at the ack clock; returns in the clock where done_h is expected.
  task automatic serve(input logic [2:0] f, input int acyc, input int pat, input ebus_word_t w,
                       input int g, input logic [5:0] fm, input bit hold);
    exp_t e;
    build(pat, w, g);
    fm_cur = fm;
    e = model(acyc, fm);
    exp_q.push_back(e);
    chk("sel_at_ack", {d04, d05, d06}, f);
    chk("func_low_at_ack", f12, 0);
    chk("err_clr_at_ack", err_h, 0);
    if (!hold) req_h = 1'b0;
    ebus = busv[0];
    for (int k = 1; k <= e.done_cyc - acyc; k++) begin
      @(posedge clk_h); #1;
      ebus = busv[k];
      if (k == 1) chk("func_high_settle", f12, 1);
    end
  endtask

  task automatic hold_gap(output int acyc2);
    bit selz;
    int gap;
    selz = 0; gap = -1; acyc2 = -1;
    for (int g = 1; g <= H + 8; g++) begin
      @(posedge clk_h); #1;
      if (ack_h) begin
        acyc2 = cyc;
        gap = g;
        break;
      end
      if ({d04, d05, d06} == 3'b000) selz = 1;
    end
    chk("hold_gap", gap, H + 2);
    chk("sel_low_between", selz, 1);
    if (acyc2 < 0) abort = 1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_h); #1;
      if (!busy_h) return;
    end
    chk("idle_timeout", busy_h, 0);
    abort = 1;
  endtask

  task automatic run_all();
    int a, a2;
    ebus_word_t w;
    logic [5:0] fm;
    logic [2:0] f;

    request(3'b101, a); if (abort) return;
    serve(3'b101, a, 0, 36'o123456701234, 0, 6'h0, 0);
    wait_idle(); if (abort) return;

    request(3'b010, a); if (abort) return;
    serve(3'b010, a, 1, rnd_word(), 0, 6'h0, 0);
    wait_idle(); if (abort) return;

    request(3'b111, a); if (abort) return;
    serve(3'b111, a, 2, rnd_word(), 0, 6'h0, 0);
    wait_idle(); if (abort) return;
    chk("func_low_after_err", f12, 0);

    request(3'b011, a); if (abort) return;
    serve(3'b011, a, 0, rnd_word(), 0, 6'h0, 1);
    hold_gap(a2); if (abort) return;
    serve(3'b011, a2, 0, rnd_word(), 0, 6'h0, 0);
    wait_idle(); if (abort) return;

    request(3'b110, a); if (abort) return;
    req_h = 1'b0;
    ebus = rnd_word();
    repeat (2) begin @(posedge clk_h); #1; end
    crobar_h = 1'b1;
    #1;
    chk("crobar_func", f12, 0);
    chk("crobar_sel", {d04, d05, d06}, 0);
    chk("crobar_busy", busy_h, 0);
    #2 crobar_h = 1'b0;
    repeat (30) @(posedge clk_h);
    #1;
    request(3'b001, a); if (abort) return;
    serve(3'b001, a, 0, rnd_word(), 0, 6'h0, 0);
    wait_idle(); if (abort) return;

`ifdef EDP_DIAG_PAR_CHK_EN
    w = rnd_word();
    w[18 +: 6] = 6'o07;
    for (int i = 0; i < 6; i++) fm[i] = ^w[6*i +: 6];
    fm[3] = 1'b0;
    request(3'b100, a); if (abort) return;
    serve(3'b100, a, 0, w, 0, fm, 0);
    wait_idle(); if (abort) return;
`endif

    for (int n = 0; n < 40; n++) begin
      f  = 3'($urandom_range(0, 7));
      fm = 6'($urandom_range(0, 63));
      w  = rnd_word();
      request(f, a); if (abort) return;
      serve(f, a, $urandom_range(0, 4), w, $urandom_range(0, R), fm, 0);
      wait_idle(); if (abort) return;
    end
  endtask

  always @(negedge clk_h) begin
    if (!crobar_h && done_h) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done_h at cycle %0d with no read outstanding", cyc);
      end else begin
        me = exp_q.pop_front();
        chk("rd_data", rd_data_h, me.data);
        chk("err", err_h, me.err);
        chk("done_cycle", cyc, me.done_cyc);
        chk("func_low_at_done", f12, 0);
`ifdef EDP_DIAG_PAR_CHK_EN
        if (!me.err) chk("par_err", par_err_h, me.par);
`endif
      end
    end
  end

  initial begin
    crobar_h = 1'b1;
    req_h = 1'b0;
    req_func_h = 3'b000;
    ebus = '0;
    fm_cur = '0;
    repeat (3) @(posedge clk_h);
    #1;
    chk("rst_ack", ack_h, 0);
    chk("rst_busy", busy_h, 0);
    chk("rst_done", done_h, 0);
    chk("rst_data", rd_data_h, 0);
    chk("rst_err", err_h, 0);
    chk("rst_func", f12, 0);
    chk("rst_sel", {d04, d05, d06}, 0);
    crobar_h = 1'b0;
    @(posedge clk_h); #1;
    run_all();
    repeat (5) @(posedge clk_h);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
